// File: rtl/fcl_pro_seq_pkg.sv
// rtl/fcl_pro_seq_pkg.sv - shared widths, engine output array type and sequencer states
package fcl_pro_seq_pkg;

  localparam int PRO_WIDTH    = 9;
  localparam int PRO_PARALLEL = 8;

  typedef logic signed [PRO_WIDTH-1:0] pro_word_t;
  typedef pro_word_t [PRO_PARALLEL-1:0] pro_vec_t;

  typedef enum logic {
    ST_ACCUM   = 1'b0,
    ST_CAPTURE = 1'b1
  } seq_state_e;

endpackage

// File: rtl/bin_word_fifo.sv
// rtl/bin_word_fifo.sv - binarized output word FIFO, head word presented from storage registers
module bin_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign w_pop     = out_valid && out_ready;
  // When full, the slot being written is the head being popped this same cycle.
  assign w_push    = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fcl_pro_seq.sv
// rtl/fcl_pro_seq.sv - feeds a frame of pixels to the parallel engine and binarizes the sums
module fcl_pro_seq #(
  parameter int PRO_WIDTH    = fcl_pro_seq_pkg::PRO_WIDTH,
  parameter int PRO_PARALLEL = fcl_pro_seq_pkg::PRO_PARALLEL,
  parameter int FRAME_LEN    = 784,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pix_valid,
  output logic                              pix_ready,
  input  logic [PRO_WIDTH-1:0]              pix_data,
  input  logic [PRO_PARALLEL-1:0]           pix_w,
  output logic [PRO_WIDTH-1:0]              pro_input,
  output logic [PRO_PARALLEL-1:0]           pro_w,
  output logic                              pro_acc_en,
  input  logic [PRO_PARALLEL*PRO_WIDTH-1:0] pro_out,
  input  logic [PRO_PARALLEL*PRO_WIDTH-1:0] thresh,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PRO_PARALLEL-1:0]           out_data,
  output logic [15:0]                       frame_cnt
);

  import fcl_pro_seq_pkg::*;

  localparam int            CW   = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  seq_state_e              r_state;
  seq_state_e              w_state_nxt;
  logic [CW-1:0]           r_pix_cnt;
  logic [CW-1:0]           w_pix_cnt_nxt;
  logic [15:0]             r_frame_cnt;
  logic                    w_fire;
  logic                    w_last;
  logic                    w_push;
  logic                    w_fifo_full;
  logic [PRO_PARALLEL-1:0] w_word;

  assign w_last     = (r_pix_cnt == LAST);
  // Holding the last pixel while the FIFO is full guarantees room for the capture push.
  assign pix_ready  = (r_state == ST_ACCUM) && !(w_last && w_fifo_full);
  assign w_fire     = pix_valid && pix_ready;
  assign pro_input  = w_fire ? pix_data : '0;
  assign pro_w      = w_fire ? pix_w : '1;
  assign pro_acc_en = (r_pix_cnt != '0);
  assign frame_cnt  = r_frame_cnt;

  always_comb begin
    w_state_nxt   = r_state;
    w_pix_cnt_nxt = r_pix_cnt;
    w_push        = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        if (w_fire) begin
          if (w_last) begin
            w_pix_cnt_nxt = '0;
            w_state_nxt   = ST_CAPTURE;
          end else begin
            w_pix_cnt_nxt = r_pix_cnt + 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        w_push      = 1'b1;
        w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < PRO_PARALLEL; i++) begin
      w_word[i] = $signed(pro_out[i*PRO_WIDTH +: PRO_WIDTH]) >=
                  $signed(thresh[i*PRO_WIDTH +: PRO_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_pix_cnt   <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pix_cnt <= w_pix_cnt_nxt;
      if (w_push) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  bin_word_fifo #(
    .WIDTH (PRO_PARALLEL),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_word),
    .full      (w_fifo_full),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_fcl_pro_seq.sv
// tb/tb_fcl_pro_seq.sv - scoreboard bench for fcl_pro_seq with a binary-weight engine model
module tb_fcl_pro_seq;

  localparam int W  = 9;
  localparam int P  = 8;
  localparam int FL = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           pix_valid;
  logic           pix_ready;
  logic [W-1:0]   pix_data;
  logic [P-1:0]   pix_w;
  logic [W-1:0]   pro_input;
  logic [P-1:0]   pro_w;
  logic           pro_acc_en;
  logic [P*W-1:0] pro_out;
  logic [P*W-1:0] thresh;
  logic           out_valid;
  logic           out_ready;
  logic [P-1:0]   out_data;
  logic [15:0]    frame_cnt;

  logic signed [W-1:0] acc [P];
  logic signed [W-1:0] th  [P];
  logic [P-1:0]        exp_q [$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fcl_pro_seq #(
    .PRO_WIDTH    (W),
    .PRO_PARALLEL (P),
    .FRAME_LEN    (FL),
    .FIFO_DEPTH   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_w      (pix_w),
    .pro_input  (pro_input),
    .pro_w      (pro_w),
    .pro_acc_en (pro_acc_en),
    .pro_out    (pro_out),
    .thresh     (thresh),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_cnt  (frame_cnt)
  );

  // Engine: weight 1 adds the pixel, weight 0 subtracts it; acc_en=0 loads.
  always @(posedge clk) begin
    for (int c = 0; c < P; c++) begin
      if (pro_acc_en)
        acc[c] <= acc[c] + (pro_w[c] ? $signed(pro_input) : -$signed(pro_input));
      else
        acc[c] <= pro_w[c] ? $signed(pro_input) : -$signed(pro_input);
    end
  end

  always_comb begin
    pro_out = '0;
    thresh  = '0;
    for (int c = 0; c < P; c++) begin
      pro_out[c*W +: W] = acc[c];
      thresh[c*W +: W]  = th[c];
    end
  end

  function automatic int pix_of(input int i);
    return 10 * (i + 1);
  endfunction

  function automatic logic [P-1:0] model_word(input logic [P-1:0] w);
    logic [P-1:0] r;
    int s;
    for (int c = 0; c < P; c++) begin
      s = 0;
      for (int i = 0; i < FL; i++) s += w[c] ? pix_of(i) : -pix_of(i);
      r[c] = (s >= int'(th[c]));
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pix_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Sends the first npix pixels of the standard frame; a full frame queues its expected word.
  task automatic send_frame(input string name, input logic [P-1:0] w, input bit bubbles, input int npix);
    int i = 0;
    int k = 0;
    while (i < npix && k < 100) begin
      @(negedge clk);
      if (bubbles && (k % 2 == 1)) begin
        pix_valid = 1'b0;
        #1;
        checks++;
        if (pro_input !== '0 || pro_w !== '1) begin
          failures++;
          $display("FAIL %s bubble: pro_input=%0d pro_w=%h required 0/ff", name, pro_input, pro_w);
        end
      end else begin
        pix_valid = 1'b1; pix_data = W'(pix_of(i)); pix_w = w;
        #1;
        if (pix_ready) begin
          checks++;
          if (pro_acc_en !== (i != 0) || pro_input !== W'(pix_of(i))) begin
            failures++;
            $display("FAIL %s pixel%0d: acc_en=%b pro_input=%0d required %b/%0d",
                     name, i, pro_acc_en, pro_input, (i != 0), pix_of(i));
          end
          i++;
        end
      end
      k++;
    end
    checks++;
    if (i < npix) begin
      failures++;
      $display("FAIL %s timeout: sent %0d required %0d pixels", name, i, npix);
    end
    if (npix == FL) exp_q.push_back(model_word(w));
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic collect_word(input string name);
    int g = 0;
    logic [P-1:0] e;
    while (!out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (!out_valid || exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s word: out_valid=%b queued=%0d required 1/>0", name, out_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (out_data !== e) begin
        failures++;
        $display("FAIL %s word: out_data=%h required %h", name, out_data, e);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || pix_ready !== 1'b1 || pro_acc_en !== 1'b0 ||
        pro_input !== '0 || frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset: valid=%b ready=%b acc_en=%b input=%0d frames=%0d required 0/1/0/0/0",
               out_valid, pix_ready, pro_acc_en, pro_input, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    send_frame("b2b", 8'hFF, 1'b0, FL);
    #1;
    checks++;
    if (out_valid !== 1'b0 || pix_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b capture: out_valid=%b pix_ready=%b required 0/0", out_valid, pix_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b latency: out_valid=%b required 1", out_valid);
    end
    collect_word("b2b");
    checks++;
    if (frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL b2b frame_cnt: %0d required 1", frame_cnt);
    end
  endtask

  task automatic test_weights_zero();
    send_frame("w0", 8'h00, 1'b0, FL);
    collect_word("w0");
  endtask

  task automatic test_thresh_boundary();
    th[0] = 9'sd101;
    th[1] = 9'sd100;
    send_frame("thr", 8'hFF, 1'b0, FL);
    collect_word("thr");
    th[0] = '0;
    th[1] = '0;
  endtask

  task automatic test_bubbles();
    send_frame("bub", 8'hFF, 1'b1, FL);
    collect_word("bub");
    send_frame("bub_mix", 8'h3C, 1'b1, FL);
    collect_word("bub_mix");
  endtask

  task automatic test_backpressure();
    logic [P-1:0] e;
    do_reset();
    send_frame("bp1", 8'hFF, 1'b0, FL);
    send_frame("bp2", 8'h0F, 1'b0, FL);
    send_frame("bp3", 8'hA5, 1'b0, FL - 1);
    repeat (3) begin
      @(negedge clk);
      pix_valid = 1'b1; pix_data = W'(pix_of(FL - 1)); pix_w = 8'hA5;
      #1;
      checks++;
      if (pix_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp stall: pix_ready=%b required 0", pix_ready);
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp head: out_data=%h valid=%b required %h/1", out_data, out_valid, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++;
    if (pix_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp release: pix_ready=%b required 1", pix_ready);
    end
    exp_q.push_back(model_word(8'hA5));
    @(negedge clk);
    pix_valid = 1'b0;
    collect_word("bp_order2");
    collect_word("bp_order3");
    checks++;
    if (frame_cnt !== 16'd3) begin
      failures++;
      $display("FAIL bp frame_cnt: %0d required 3", frame_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame("mid", 8'hFF, 1'b0, 2);
    do_reset();
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || frame_cnt !== 16'd0) begin
        failures++;
        $display("FAIL mid discard: out_valid=%b frame_cnt=%0d required 0/0", out_valid, frame_cnt);
      end
    end
    send_frame("mid_next", 8'h5A, 1'b0, FL);
    collect_word("mid_next");
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; out_ready = 1'b0;
    pix_data = '0; pix_w = '0;
    for (int c = 0; c < P; c++) th[c] = '0;
    test_reset();
    test_back_to_back();
    test_weights_zero();
    test_thresh_boundary();
    test_bubbles();
    test_backpressure();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: %0d words never emerged, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
